dct_coef_quantizer: RTL and testbench

//  Downstream stage of the 2-D DCT controller/MAC pair. Captures each finished DCT coefficient on the

---
 rtl/dct_pkg.sv | 63 ++++++
 rtl/dct_round_sat.sv | 32 +++
 rtl/dct_coef_quantizer.sv | 142 ++++++++++++++
 tb/tb_dct_coef_quantizer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared constants for the DCT coefficient path: quantizer table, its
// reciprocals, the raster-to-zigzag map and default datapath widths.
package dct_pkg;

  localparam int ACC_W_DEF = 24;
  localparam int OUT_W_DEF = 12;
  localparam int FRAC_DEF  = 16;
  localparam int BLK_SIZE  = 64;

  typedef logic [5:0] coef_idx_t;
  typedef logic [FRAC_DEF:0] recip_t;

  // JPEG luminance quantizer, raster order (row-major, x is the fast index)
  localparam logic [7:0] QTAB [BLK_SIZE] = '{
    8'd16,  8'd11,  8'd10,  8'd16,  8'd24,  8'd40,  8'd51,  8'd61,
    8'd12,  8'd12,  8'd14,  8'd19,  8'd26,  8'd58,  8'd60,  8'd55,
    8'd14,  8'd13,  8'd16,  8'd24,  8'd40,  8'd57,  8'd69,  8'd56,
    8'd14,  8'd17,  8'd22,  8'd29,  8'd51,  8'd87,  8'd80,  8'd62,
    8'd18,  8'd22,  8'd37,  8'd56,  8'd68,  8'd109, 8'd103, 8'd77,
    8'd24,  8'd35,  8'd55,  8'd64,  8'd81,  8'd104, 8'd113, 8'd92,
    8'd49,  8'd64,  8'd78,  8'd87,  8'd103, 8'd121, 8'd120, 8'd101,
    8'd72,  8'd92,  8'd95,  8'd98,  8'd112, 8'd100, 8'd103, 8'd99
  };

  // round(2^FRAC / q), evaluated at elaboration time only
  function automatic recip_t recip_of(input logic [7:0] q);
    logic [31:0] num;
    num = (32'd1 << FRAC_DEF) + 32'(q >> 1);
    return recip_t'(num / 32'(q));
  endfunction

  localparam recip_t RECIP [BLK_SIZE] = '{
    recip_of(QTAB[0]),  recip_of(QTAB[1]),  recip_of(QTAB[2]),  recip_of(QTAB[3]),
    recip_of(QTAB[4]),  recip_of(QTAB[5]),  recip_of(QTAB[6]),  recip_of(QTAB[7]),
    recip_of(QTAB[8]),  recip_of(QTAB[9]),  recip_of(QTAB[10]), recip_of(QTAB[11]),
    recip_of(QTAB[12]), recip_of(QTAB[13]), recip_of(QTAB[14]), recip_of(QTAB[15]),
    recip_of(QTAB[16]), recip_of(QTAB[17]), recip_of(QTAB[18]), recip_of(QTAB[19]),
    recip_of(QTAB[20]), recip_of(QTAB[21]), recip_of(QTAB[22]), recip_of(QTAB[23]),
    recip_of(QTAB[24]), recip_of(QTAB[25]), recip_of(QTAB[26]), recip_of(QTAB[27]),
    recip_of(QTAB[28]), recip_of(QTAB[29]), recip_of(QTAB[30]), recip_of(QTAB[31]),
    recip_of(QTAB[32]), recip_of(QTAB[33]), recip_of(QTAB[34]), recip_of(QTAB[35]),
    recip_of(QTAB[36]), recip_of(QTAB[37]), recip_of(QTAB[38]), recip_of(QTAB[39]),
    recip_of(QTAB[40]), recip_of(QTAB[41]), recip_of(QTAB[42]), recip_of(QTAB[43]),
    recip_of(QTAB[44]), recip_of(QTAB[45]), recip_of(QTAB[46]), recip_of(QTAB[47]),
    recip_of(QTAB[48]), recip_of(QTAB[49]), recip_of(QTAB[50]), recip_of(QTAB[51]),
    recip_of(QTAB[52]), recip_of(QTAB[53]), recip_of(QTAB[54]), recip_of(QTAB[55]),
    recip_of(QTAB[56]), recip_of(QTAB[57]), recip_of(QTAB[58]), recip_of(QTAB[59]),
    recip_of(QTAB[60]), recip_of(QTAB[61]), recip_of(QTAB[62]), recip_of(QTAB[63])
  };

  // Raster index -> zigzag position
  localparam coef_idx_t ZIGZAG [BLK_SIZE] = '{
    6'd0,  6'd1,  6'd5,  6'd6,  6'd14, 6'd15, 6'd27, 6'd28,
    6'd2,  6'd4,  6'd7,  6'd13, 6'd16, 6'd26, 6'd29, 6'd42,
    6'd3,  6'd8,  6'd12, 6'd17, 6'd25, 6'd30, 6'd41, 6'd43,
    6'd9,  6'd11, 6'd18, 6'd24, 6'd31, 6'd40, 6'd44, 6'd53,
    6'd10, 6'd19, 6'd23, 6'd32, 6'd39, 6'd45, 6'd52, 6'd54,
    6'd20, 6'd22, 6'd33, 6'd38, 6'd46, 6'd51, 6'd55, 6'd60,
    6'd21, 6'd34, 6'd37, 6'd47, 6'd50, 6'd56, 6'd59, 6'd61,
    6'd35, 6'd36, 6'd48, 6'd49, 6'd57, 6'd58, 6'd62, 6'd63
  };

endpackage

// File: rtl/dct_round_sat.sv
// Fixed-point product -> integer: round half away from zero, drop FRAC
// fraction bits, then clamp to the signed OUT_W range.
module dct_round_sat #(
  parameter int P_W   = 42,
  parameter int FRAC  = 16,
  parameter int OUT_W = 12
) (
  input  logic signed [P_W-1:0]   prod_i,
  output logic signed [OUT_W-1:0] q_o
);

  localparam logic [P_W-1:0] HALF    = P_W'(1) << (FRAC - 1);
  localparam logic [P_W-1:0] POS_LIM = (P_W'(1) << (OUT_W - 1)) - P_W'(1);
  localparam logic [P_W-1:0] NEG_LIM = P_W'(1) << (OUT_W - 1);

  logic           neg;
  logic [P_W-1:0] mag;
  logic [P_W-1:0] rnd;

  // Work on the magnitude so rounding is symmetric about zero
  always_comb begin
    neg = prod_i[P_W-1];
    mag = neg ? $unsigned(-prod_i) : $unsigned(prod_i);
    rnd = (mag + HALF) >> FRAC;
    if (!neg) begin
      q_o = (rnd > POS_LIM) ? OUT_W'(POS_LIM) : rnd[OUT_W-1:0];
    end else begin
      q_o = (rnd > NEG_LIM) ? OUT_W'(NEG_LIM) : -(rnd[OUT_W-1:0]);
    end
  end

endmodule

// File: rtl/dct_coef_quantizer.sv
// Captures DCT coefficients on the controller's ready pulse, quantizes them
// with the reciprocal table, saturates, and writes them in zigzag order.
// Pipeline: capture -> table lookup -> multiply -> round/saturate/write.
module dct_coef_quantizer
  import dct_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    start,
  input  logic                    ready,
  input  logic [2:0]              x,
  input  logic [2:0]              y,
  input  logic signed [ACC_W-1:0] mac_in,
  output logic                    wr_en,
  output logic [5:0]              wr_addr,
  output logic signed [OUT_W-1:0] wr_data,
  output logic                    block_done,
  output logic                    seq_err
);

  localparam int P_W = ACC_W + FRAC + 2;

  // *_cnt_q marks entries that belong to the current block; start clears
  // it for everything already in flight so old writes do not count.
  logic                    s1_valid_q, s1_cnt_q;
  logic signed [ACC_W-1:0] s1_mac_q;
  coef_idx_t               s1_idx_q;
  logic                    s2_valid_q, s2_cnt_q;
  logic signed [ACC_W-1:0] s2_mac_q;
  logic [FRAC:0]           s2_recip_q;
  coef_idx_t               s2_zz_q;
  logic                    s3_valid_q, s3_cnt_q;
  logic signed [P_W-1:0]   s3_prod_q;
  coef_idx_t               s3_zz_q;

  coef_idx_t               exp_idx_q, exp_idx_d, exp_base;
  logic                    seq_err_q, seq_err_d;
  logic [5:0]              wr_cnt_q, wr_cnt_d;
  logic                    block_done_q, block_done_d;
  logic                    count_now;
  logic                    wr_en_q;
  coef_idx_t               wr_addr_q;
  logic signed [OUT_W-1:0] wr_data_q;
  logic signed [OUT_W-1:0] rounded;

  // Order check at capture; start restarts the block at index 0
  always_comb begin
    exp_base  = start ? '0 : exp_idx_q;
    exp_idx_d = exp_base;
    seq_err_d = start ? 1'b0 : seq_err_q;
    if (ready) begin
      if (coef_idx_t'({y, x}) != exp_base) seq_err_d = 1'b1;
      exp_idx_d = exp_base + 6'd1;
    end
  end

  // Count writes of the current block; flag the last one
  always_comb begin
    count_now    = s3_valid_q & s3_cnt_q & ~start;
    wr_cnt_d     = start ? '0 : wr_cnt_q;
    block_done_d = 1'b0;
    if (count_now) begin
      block_done_d = (wr_cnt_q == 6'(BLK_SIZE - 1));
      wr_cnt_d     = wr_cnt_q + 6'd1;
    end
  end

  dct_round_sat #(
    .P_W  (P_W),
    .FRAC (FRAC),
    .OUT_W(OUT_W)
  ) u_round_sat (
    .prod_i(s3_prod_q),
    .q_o   (rounded)
  );

  // Pipeline registers, counters and registered outputs
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      s1_valid_q   <= 1'b0;
      s1_cnt_q     <= 1'b0;
      s1_mac_q     <= '0;
      s1_idx_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_cnt_q     <= 1'b0;
      s2_mac_q     <= '0;
      s2_recip_q   <= '0;
      s2_zz_q      <= '0;
      s3_valid_q   <= 1'b0;
      s3_cnt_q     <= 1'b0;
      s3_prod_q    <= '0;
      s3_zz_q      <= '0;
      exp_idx_q    <= '0;
      seq_err_q    <= 1'b0;
      wr_cnt_q     <= '0;
      block_done_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      s1_valid_q <= ready;
      s1_cnt_q   <= ready;
      if (ready) begin
        s1_mac_q <= mac_in;
        s1_idx_q <= coef_idx_t'({y, x});
      end
      s2_valid_q <= s1_valid_q;
      s2_cnt_q   <= s1_cnt_q & ~start;
      if (s1_valid_q) begin
        s2_mac_q   <= s1_mac_q;
        s2_recip_q <= (FRAC + 1)'(RECIP[s1_idx_q]);
        s2_zz_q    <= ZIGZAG[s1_idx_q];
      end
      s3_valid_q <= s2_valid_q;
      s3_cnt_q   <= s2_cnt_q & ~start;
      if (s2_valid_q) begin
        s3_prod_q <= P_W'(s2_mac_q) * P_W'($signed({1'b0, s2_recip_q}));
        s3_zz_q   <= s2_zz_q;
      end
      exp_idx_q    <= exp_idx_d;
      seq_err_q    <= seq_err_d;
      wr_cnt_q     <= wr_cnt_d;
      block_done_q <= block_done_d;
      wr_en_q      <= s3_valid_q;
      if (s3_valid_q) begin
        wr_addr_q <= s3_zz_q;
        wr_data_q <= rounded;
      end
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign block_done = block_done_q;
  assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_dct_coef_quantizer.sv
// Randomized bench for dct_coef_quantizer against a transaction-level model.
module tb_dct_coef_quantizer;

  logic               clk = 1'b0;
  logic               rst_in = 1'b1;
  logic               start = 1'b0;
  logic               ready = 1'b0;
  logic [2:0]         x = '0;
  logic [2:0]         y = '0;
  logic signed [23:0] mac_in = '0;
  logic               wr_en;
  logic [5:0]         wr_addr;
  logic signed [11:0] wr_data;
  logic               block_done;
  logic               seq_err;

  dct_coef_quantizer dut (
    .clk       (clk),
    .rst_in    (rst_in),
    .start     (start),
    .ready     (ready),
    .x         (x),
    .y         (y),
    .mac_in    (mac_in),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .block_done(block_done),
    .seq_err   (seq_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     due;
    int     addr;
    longint data;
    bit     cnt;
  } exp_t;

  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  int     qtab [64] = '{16,11,10,16,24,40,51,61, 12,12,14,19,26,58,60,55,
                        14,13,16,24,40,57,69,56, 14,17,22,29,51,87,80,62,
                        18,22,37,56,68,109,103,77, 24,35,55,64,81,104,113,92,
                        49,64,78,87,103,121,120,101, 72,92,95,98,112,100,103,99};
  int     zz_tab [64];
  exp_t   pend [$];
  int     m_exp = 0;
  int     m_cnt = 0;
  bit     m_err = 0;
  int     last_addr = 0;
  longint last_data = 0;
  int     obs_addr = 0;
  longint obs_data = 0;
  int     done_seen = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Quantization by the arithmetic rule: multiply by round(65536/Q),
  // round half away from zero, clamp to 12-bit signed.
  function automatic longint quant(input longint mac, input int idx);
    longint recip, p, mag, r, v;
    recip = (65536 + qtab[idx] / 2) / qtab[idx];
    p     = mac * recip;
    mag   = (p < 0) ? -p : p;
    r     = (mag + 32768) / 65536;
    v     = (p < 0) ? -r : r;
    if (v > 2047) v = 2047;
    if (v < -2048) v = -2048;
    return v;
  endfunction

  // Walk the anti-diagonals to number raster positions in zigzag order
  task automatic build_zigzag();
    int k;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      for (int a = (s < 8 ? s : 7); a >= 0 && (s - a) < 8; a--) begin
        if (s % 2 == 0) zz_tab[a * 8 + (s - a)] = k;
        else            zz_tab[(s - a) * 8 + a] = k;
        k++;
      end
    end
  endtask

  // One clock: drive inputs, advance model, compare outputs
  task automatic step(input bit st, input bit rd, input int xx, input int yy, input longint mac);
    exp_t e;
    bit   exp_en, exp_done;
    int   idx;
    start  = st;
    ready  = rd;
    x      = 3'(xx);
    y      = 3'(yy);
    mac_in = 24'(mac);
    @(posedge clk);
    cyc++;
    if (st) begin
      foreach (pend[i]) pend[i].cnt = 0;
      m_exp = 0;
      m_cnt = 0;
      m_err = 0;
    end
    if (rd) begin
      idx = yy * 8 + xx;
      if (idx != m_exp) m_err = 1;
      m_exp = (m_exp + 1) % 64;
      pend.push_back('{cyc + 3, zz_tab[idx], quant(mac, idx), 1'b1});
    end
    exp_en   = 0;
    exp_done = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e = pend.pop_front();
      exp_en    = 1;
      last_addr = e.addr;
      last_data = e.data;
      if (e.cnt) begin
        exp_done = (m_cnt == 63);
        m_cnt    = (m_cnt + 1) % 64;
      end
    end
    #1;
    check("wr_en", longint'(wr_en), longint'(exp_en));
    check("wr_addr", longint'(wr_addr), longint'(last_addr));
    check("wr_data", longint'(wr_data), last_data);
    check("block_done", longint'(block_done), longint'(exp_done));
    check("seq_err", longint'(seq_err), longint'(m_err));
    if (wr_en) begin
      obs_addr = int'(wr_addr);
      obs_data = longint'(wr_data);
    end
    if (block_done) done_seen++;
    $display("cyc %0d st=%0d rd=%0d idx=%0d wr_en=%0d addr=%0d data=%0d done=%0d err=%0d",
             cyc, st, rd, yy * 8 + xx, wr_en, wr_addr, wr_data, block_done, seq_err);
  endtask

  task automatic flush();
    repeat (4) step(0, 0, 0, 0, 0);
  endtask

  function automatic longint rand_mac();
    logic signed [23:0] r;
    r = 24'($urandom);
    case ($urandom_range(0, 5))
      0:       return 8388607;
      1:       return -8388608;
      2:       return longint'($signed(24'($urandom_range(0, 4000)))) - 2000;
      default: return longint'(r);
    endcase
  endfunction

  task automatic full_block(input int max_gap);
    step(1, 0, 0, 0, 0);
    done_seen = 0;
    for (int i = 0; i < 64; i++) begin
      step(0, 1, i % 8, i / 8, rand_mac());
      repeat ($urandom_range(0, max_gap)) step(0, 0, 0, 0, 0);
    end
    flush();
    check("done_once", done_seen, 1);
    check("blk_seq_err", longint'(seq_err), 0);
  endtask

  initial begin
    build_zigzag();
    // reset state
    #2;
    check("rst_wr_en", longint'(wr_en), 0);
    check("rst_wr_addr", longint'(wr_addr), 0);
    check("rst_wr_data", longint'(wr_data), 0);
    check("rst_done", longint'(block_done), 0);
    check("rst_seq_err", longint'(seq_err), 0);
    @(posedge clk);
    #1 rst_in = 1'b0;

    // rounding at Q=16
    step(1, 1, 0, 0, 1000);    flush(); check("q16_pos", obs_data, 63);
    step(1, 1, 0, 0, -1000);   flush(); check("q16_neg", obs_data, -63);
    // saturation
    step(1, 1, 0, 0, 8388607);  flush(); check("sat_pos", obs_data, 2047);
    step(1, 1, 0, 0, -8388608); flush(); check("sat_neg", obs_data, -2048);
    // zigzag addresses
    step(1, 1, 1, 0, 500); flush(); check("zz_10", obs_addr, 1);
    step(1, 1, 0, 1, 500); flush(); check("zz_01", obs_addr, 2);
    step(1, 1, 0, 2, 500); flush(); check("zz_02", obs_addr, 3);
    step(1, 1, 7, 7, 500); flush(); check("zz_77", obs_addr, 63);

    // full blocks: sparse, back-to-back, random gaps
    full_block(0);
    step(1, 0, 0, 0, 0);
    done_seen = 0;
    for (int i = 0; i < 64; i++) begin
      step(0, 1, i % 8, i / 8, rand_mac());
      repeat (8) step(0, 0, 0, 0, 0);
    end
    flush();
    check("sparse_done_once", done_seen, 1);
    check("sparse_seq_err", longint'(seq_err), 0);
    full_block(2);

    // order error is sticky until start
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 3000);
    flush();
    check("oe_addr", obs_addr, 1);
    check("oe_set", longint'(seq_err), 1);
    for (int i = 2; i < 10; i++) step(0, 1, i % 8, i / 8, rand_mac());
    flush();
    check("oe_sticky", longint'(seq_err), 1);
    step(1, 0, 0, 0, 0);
    check("oe_cleared", longint'(seq_err), 0);

    // reset with two coefficients in flight
    step(1, 1, 0, 0, 1234);
    step(0, 1, 1, 0, 4321);
    rst_in = 1'b1;
    #2;
    check("midrst_wr_en", longint'(wr_en), 0);
    check("midrst_addr", longint'(wr_addr), 0);
    check("midrst_data", longint'(wr_data), 0);
    check("midrst_err", longint'(seq_err), 0);
    pend.delete();
    m_exp = 0; m_cnt = 0; m_err = 0; last_addr = 0; last_data = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_in = 1'b0;
    flush();
    flush();
    step(1, 1, 0, 0, 777);
    flush();
    check("post_rst_err", longint'(seq_err), 0);
    check("post_rst_addr", obs_addr, 0);

    // random traffic, mostly in order, with occasional start and stray indices
    for (int i = 0; i < 400; i++) begin
      bit rd, st;
      int idx;
      st  = ($urandom_range(0, 60) == 0);
      rd  = ($urandom_range(0, 2) != 0);
      idx = ($urandom_range(0, 30) == 0) ? int'($urandom_range(0, 63)) : (st ? 0 : m_exp);
      step(st, rd, idx % 8, idx / 8, rand_mac());
    end
    flush();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout cycle %0d: got running expected finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
